// File: rtl/rst_addr_codec_pkg.sv
// Shared sizes and types for the Register Status Table address codec.
package rst_pkg;

  localparam int RST_ENTRIES = 32;
  localparam int RST_ADDR_W  = 5;

  typedef logic [RST_ADDR_W-1:0]  rst_addr_t;
  typedef logic [RST_ENTRIES-1:0] rst_mask_t;

endpackage

// File: rtl/rst_addr_codec_prio_enc32.sv
// 32->5 priority encoder. Bit 0 has the highest priority.
// valid is high when any request bit is set.
module rst_prio_enc32
  import rst_pkg::*;
(
  input  rst_mask_t req,
  output rst_addr_t idx,
  output logic      valid
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = RST_ENTRIES - 1; i >= 0; i--) begin
      if (req[i]) idx = rst_addr_t'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/rst_addr_codec.sv
// RST address codec: a one-hot write-mask decoder and a lowest-first clear encoder.
// The encoder output can optionally be registered.
module rst_addr_codec
  import rst_pkg::*;
#(
  parameter int N_ENTRIES = RST_ENTRIES,
  parameter int ADDR_W    = RST_ADDR_W,
  parameter bit REG_OUT   = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    Waddr_rst,
  input  logic                 Wen_rst,
  output logic [N_ENTRIES-1:0] Wen0_rst,
  input  logic [N_ENTRIES-1:0] wen1_rst,
  output logic [ADDR_W-1:0]    Addr,
  output logic                 Clear_en
);

  rst_addr_t enc_idx;
  logic      enc_valid;

  // Decoder is always combinational. Reset does not affect it.
  always_comb begin
    Wen0_rst = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (Wen_rst && (Waddr_rst == ADDR_W'(i))) Wen0_rst[i] = 1'b1;
    end
  end

  rst_prio_enc32 u_enc (
    .req   (wen1_rst),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          Addr     <= '0;
          Clear_en <= 1'b0;
        end else begin
          Addr     <= enc_idx;
          Clear_en <= enc_valid;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;
      assign Addr           = enc_idx;
      assign Clear_en       = enc_valid;
    end
  endgenerate

endmodule

// File: tb/tb_rst_addr_codec.sv
// Self-checking bench for rst_addr_codec. It runs a combinational and a
// registered instance side by side against a behavioural reference.
module tb_rst_addr_codec;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  waddr = '0;
  logic        wen   = 1'b0;
  logic [31:0] wen1  = '0;
  logic [31:0] wen0_c, wen0_r;
  logic [4:0]  addr_c, addr_r;
  logic        clr_c, clr_r;

  int total = 0;
  int bad   = 0;

  logic [4:0] m_addr;
  logic       m_clr;

  always #5 clock = ~clock;

  rst_addr_codec #(.REG_OUT(1'b0)) dut_c (
    .clock(clock), .reset(reset), .Waddr_rst(waddr), .Wen_rst(wen),
    .Wen0_rst(wen0_c), .wen1_rst(wen1), .Addr(addr_c), .Clear_en(clr_c)
  );

  rst_addr_codec #(.REG_OUT(1'b1)) dut_r (
    .clock(clock), .reset(reset), .Waddr_rst(waddr), .Wen_rst(wen),
    .Wen0_rst(wen0_r), .wen1_rst(wen1), .Addr(addr_r), .Clear_en(clr_r)
  );

  function automatic logic [4:0] ref_lowest(input logic [31:0] v);
    for (int k = 0; k < 32; k++) if (v[k]) return 5'(k);
    return 5'd0;
  endfunction

  function automatic logic [31:0] ref_decode(input logic en, input logic [4:0] a);
    logic [31:0] one;
    one = 32'h1;
    return en ? (one << a) : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Registered-path reference: the result of the inputs seen at the last edge, or zero while reset is high.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_addr = 5'd0;
      m_clr  = 1'b0;
    end else begin
      m_addr = ref_lowest(wen1);
      m_clr  = (wen1 != 32'h0);
    end
  end

  always @(negedge clock) begin
    check("dec_comb",  wen0_c, ref_decode(wen, waddr));
    check("dec_reg",   wen0_r, ref_decode(wen, waddr));
    check("addr_comb", 32'(addr_c), 32'(ref_lowest(wen1)));
    check("clr_comb",  32'(clr_c), 32'(wen1 != 32'h0));
    check("addr_reg",  32'(addr_r), 32'(m_addr));
    check("clr_reg",   32'(clr_r), 32'(m_clr));
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    // Reset phase: registered outputs stay at zero, and the decoder still works.
    wen = 1'b1; waddr = 5'd3; wen1 = 32'h0000_0100;
    tick(); tick();
    settle();
    check("rst_addr_r", 32'(addr_r), 32'd0);
    check("rst_clr_r",  32'(clr_r), 32'd0);
    check("rst_dec",    wen0_r, 32'h0000_0008);
    check("rst_addr_c", 32'(addr_c), 32'd8);
    reset = 1'b0;

    // Exhaustive decode
    for (int a = 0; a < 32; a++) begin
      tick(); wen = 1'b1; waddr = 5'(a);
    end
    settle();
    check("dec31", wen0_c, 32'h8000_0000);
    tick(); waddr = 5'd5;
    settle(); check("dec5", wen0_c, 32'h0000_0020);
    tick(); wen = 1'b0; waddr = 5'd17;
    settle(); check("dec_off", wen0_c, 32'h0);

    // Single-hot encode
    for (int k = 0; k < 32; k++) begin
      tick(); wen1 = 32'h1 << k;
    end
    settle();
    check("hot31_addr", 32'(addr_c), 32'd31);
    check("hot31_clr",  32'(clr_c), 32'd1);

    // Empty and priority cases
    tick(); wen1 = 32'h0;
    settle(); check("empty_addr", 32'(addr_c), 32'd0); check("empty_clr", 32'(clr_c), 32'd0);
    tick(); wen1 = 32'h0000_0900;
    settle(); check("prio_900", 32'(addr_c), 32'd8);
    tick(); wen1 = 32'hFFFF_FFFF;
    settle(); check("all_addr", 32'(addr_c), 32'd0); check("all_clr", 32'(clr_c), 32'd1);

    // Registered latency
    tick(); wen1 = 32'h0;
    tick(); wen1 = 32'h0010_0000;
    settle();
    check("lat_hold_addr", 32'(addr_r), 32'd0);
    check("lat_hold_clr",  32'(clr_r), 32'd0);
    tick();
    check("lat_addr", 32'(addr_r), 32'd20);
    check("lat_clr",  32'(clr_r), 32'd1);

    // Reset asserted mid-cycle, held across two edges, then released with request bit 2
    reset = 1'b1;
    #1;
    check("async_addr", 32'(addr_r), 32'd0);
    check("async_clr",  32'(clr_r), 32'd0);
    tick(); tick();
    check("rsthold_addr", 32'(addr_r), 32'd0);
    check("rsthold_clr",  32'(clr_r), 32'd0);
    reset = 1'b0; wen1 = 32'h0000_0004;
    settle();
    check("rel_wait_clr", 32'(clr_r), 32'd0);
    tick();
    check("rel_addr", 32'(addr_r), 32'd2);
    check("rel_clr",  32'(clr_r), 32'd1);

    // Random vectors, including sparse requests so that many different indices come up
    for (int n = 0; n < 10000; n++) begin
      tick();
      wen   = 1'($urandom);
      waddr = 5'($urandom);
      case ($urandom_range(3))
        0: wen1 = 32'h0;
        1: wen1 = $urandom;
        default: wen1 = $urandom & $urandom & $urandom & $urandom;
      endcase
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
